// File: rtl/rst_seq_sync.sv
// Multi-channel reset synchroniser and sequencer: async assert, sync release of
// channels 0..CHAN-1 in order. Define RST_SEQ_SYNC_SWRST_EN to add sw_rst_i.
module rst_seq_sync #(
  parameter int CHAN  = 3,
  parameter int STAGE = 3,
  parameter int HOLD  = 4,
  parameter int GAP   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  output logic [CHAN-1:0] rst_n_o,
  output logic            done_o,
  output logic [1:0]      state_o
`ifdef RST_SEQ_SYNC_SWRST_EN
  ,
  input  logic            sw_rst_i
`endif
);

  localparam int CNT_MAX = (HOLD > GAP) ? HOLD : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(CHAN + 1);

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_REL  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CHAN-1:0]   rst_n_q, rst_n_d;
  logic              done_q, done_d;
  logic [STAGE-1:0]  sync_q;
  logic              s_rel;
  logic              sw_rst;
  logic              rel0;

`ifdef RST_SEQ_SYNC_SWRST_EN
  assign sw_rst = sw_rst_i;
`else
  assign sw_rst = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[STAGE-2:0], 1'b1};
  end

  assign s_rel = sync_q[STAGE-1];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_SYNC;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    rel0    = 1'b0;
    if (sw_rst && (state_q != ST_SYNC)) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        // The edge that first sees s_rel is already the first hold cycle.
        ST_SYNC: begin
          if (s_rel) begin
            if (HOLD == 1) begin
              rel0 = 1'b1;
            end else begin
              state_d = ST_HOLD;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_HOLD: begin
          if (cnt_q == CNT_W'(HOLD - 1)) rel0 = 1'b1;
          else                           cnt_d = cnt_q + 1'b1;
        end
        ST_REL: begin
          if (cnt_q == CNT_W'(GAP - 1)) begin
            rst_n_d[idx_q] = 1'b1;
            cnt_d          = '0;
            if (idx_q == IDX_W'(CHAN - 1)) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
    if (rel0) begin
      rst_n_d[0] = 1'b1;
      cnt_d      = '0;
      if (CHAN == 1) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end else begin
        state_d = ST_REL;
        idx_d   = IDX_W'(1);
      end
    end
  end

  assign rst_n_o = rst_n_q;
  assign done_o  = done_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// Bench for rst_seq_sync: default-parameter sequence, async abort, glitch,
// a CHAN=1 instance, and software reset when RST_SEQ_SYNC_SWRST_EN is defined.
module tb_rst_seq_sync;

  localparam logic [1:0] ST_SYNC = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [2:0] rst_n_o;
  logic       done_o;
  logic [1:0] state_o;
  logic       rst1 = 1'b1;
  logic [0:0] rst_n1;
  logic       done1;
  logic [1:0] state1;
  logic       sw_rst = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] rst_n;
    logic       done;
  } vec_t;

  vec_t       tbl[12];
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  rst_seq_sync #(.CHAN(3), .STAGE(3), .HOLD(4), .GAP(2)) u_dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .rst_n_o (rst_n_o),
    .done_o  (done_o),
    .state_o (state_o)
`ifdef RST_SEQ_SYNC_SWRST_EN
    ,
    .sw_rst_i(sw_rst)
`endif
  );

  rst_seq_sync #(.CHAN(1), .STAGE(2), .HOLD(1), .GAP(1)) u_dut1 (
    .clk_i   (clk),
    .rst_i   (rst1),
    .rst_n_o (rst_n1),
    .done_o  (done1),
    .state_o (state1)
`ifdef RST_SEQ_SYNC_SWRST_EN
    ,
    .sw_rst_i(1'b0)
`endif
  );

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Edge e of a sequence is compared against tbl[e] one ns after the edge.
  task automatic run_tbl(input string name, input int first, input int last);
    logic [3:0] exp;
    for (int e = first; e <= last; e++) begin
      exp_q.push_back({tbl[e].done, tbl[e].rst_n});
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("%s e%0d", name, e), {done_o, rst_n_o}, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("rst assert outs", {done_o, rst_n_o}, 4'b0000);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{3'b000, 1'b0};
    tbl[1]  = '{3'b000, 1'b0};
    tbl[2]  = '{3'b000, 1'b0};
    tbl[3]  = '{3'b000, 1'b0};
    tbl[4]  = '{3'b000, 1'b0};
    tbl[5]  = '{3'b000, 1'b0};
    tbl[6]  = '{3'b001, 1'b0};
    tbl[7]  = '{3'b001, 1'b0};
    tbl[8]  = '{3'b011, 1'b0};
    tbl[9]  = '{3'b011, 1'b0};
    tbl[10] = '{3'b111, 1'b1};
    tbl[11] = '{3'b111, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset outs", {done_o, rst_n_o}, 4'b0000);
    check("reset state", {2'b00, state_o}, {2'b00, ST_SYNC});
    check("reset outs ch1", {2'b00, done1, rst_n1}, 4'b0000);

    // Basic sequence
    @(negedge clk);
    rst_i = 1'b0;
    run_tbl("basic", 0, 11);

    // Abort after ch0 released, between edges 7 and 8
    pulse_reset();
    run_tbl("pre_abort", 0, 7);
    #2;
    rst_i = 1'b1;
    #1;
    check("abort outs", {done_o, rst_n_o}, 4'b0000);
    check("abort state", {2'b00, state_o}, {2'b00, ST_SYNC});
    @(negedge clk);
    rst_i = 1'b0;
    run_tbl("after_abort", 0, 11);

    // 1 ns glitch while in DONE
    #1;
    rst_i = 1'b1;
    #1;
    check("glitch outs", {done_o, rst_n_o}, 4'b0000);
    rst_i = 1'b0;
    run_tbl("after_glitch", 0, 11);

    // CHAN=1 instance
    @(negedge clk);
    rst1 = 1'b0;
    for (int e = 0; e <= 3; e++) begin
      logic [3:0] exp;
      exp_q.push_back((e >= 2) ? 4'b0011 : 4'b0000);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      check($sformatf("chan1 e%0d", e), {2'b00, done1, rst_n1}, exp);
    end

`ifdef RST_SEQ_SYNC_SWRST_EN
    // One-cycle pulse in DONE, sampled at edge S
    @(negedge clk);
    sw_rst = 1'b1;
    @(posedge clk);
    #1;
    sw_rst = 1'b0;
    check("sw pulse outs", {done_o, rst_n_o}, 4'b0000);
    check("sw pulse state", {2'b00, state_o}, {2'b00, ST_HOLD});
    run_tbl("sw_pulse", 3, 11);

    // Held for 5 cycles
    @(negedge clk);
    sw_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sw held outs %0d", i), {done_o, rst_n_o}, 4'b0000);
      check($sformatf("sw held state %0d", i), {2'b00, state_o}, {2'b00, ST_HOLD});
    end
    sw_rst = 1'b0;
    run_tbl("sw_held", 3, 11);

    // Asserted in SYNC: ignored
    @(negedge clk);
    rst_i  = 1'b1;
    sw_rst = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    run_tbl("sw_in_sync", 0, 2);
    sw_rst = 1'b0;
    run_tbl("sw_in_sync", 3, 11);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
